mac_array_sched: RTL and testbench

Stream scheduler that sequences the N-lane signed MAC array through back-to-back dot products of programmable length. It accepts one lane-vector pair per handshake and drives the array's `a`, `b` and `initialize` inputs. It captures the finished accumulators into a holding register and presents them on a valid/ready result stream with backpressure. It sits between the operand fetch stream and result writeback; the MAC array is instantiated alongside it on the same clock and reset.

---
 rtl/mac_array_sched.sv | 128 ++++++++++++
 tb/tb_mac_array_sched.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_array_sched.sv
// Dot-product scheduler for the N-lane signed MAC array: operand handshake, init/zero-bubble drive,
// result capture and valid/ready output. Optional stall counter output under `MAC_SCHED_PERF_EN`.
module mac_array_sched #(
  parameter int N       = 3,
  parameter int D_W     = 8,
  parameter int D_W_ACC = 16,
  parameter int LEN_W   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [LEN_W-1:0]              cfg_len,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N-1:0][D_W-1:0]         in_a,
  input  logic [N-1:0][D_W-1:0]         in_b,
  output logic [N-1:0]                  arr_init,
  output logic [N-1:0][D_W-1:0]         arr_a,
  output logic [N-1:0][D_W-1:0]         arr_b,
  input  logic [N-1:0][D_W_ACC-1:0]     arr_result,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N-1:0][D_W_ACC-1:0]     out_data,
  output logic                          busy
`ifdef MAC_SCHED_PERF_EN
  ,
  output logic [31:0]                   perf_stall
`endif
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  logic [LEN_W-1:0]              cnt_q, cnt_d;
  logic [LEN_W-1:0]              len_q, len_d;
  logic                          cap_pend_q, cap_pend_d;
  logic                          out_valid_q, out_valid_d;
  logic [N-1:0][D_W_ACC-1:0]     out_data_q, out_data_d;
  logic [LEN_W-1:0]              cfg_len_eff;
  logic [LEN_W-1:0]              len_eff;
  logic                          first;
  logic                          last;
  logic                          fire;

  always_comb begin
    cfg_len_eff = (cfg_len == '0) ? LEN_ONE : cfg_len;
    first       = (cnt_q == '0);
    len_eff     = first ? cfg_len_eff : len_q;
    last        = (cnt_q == len_eff - LEN_ONE);
    // The last element may only fire when the holding register is guaranteed free at capture time.
    in_ready    = !rst && (!last || (!cap_pend_q && (!out_valid_q || out_ready)));
    fire        = in_valid && in_ready;
  end

  // The array accumulates every cycle, so non-fire cycles must present zero operands.
  always_comb begin
    arr_a    = fire ? in_a : '0;
    arr_b    = fire ? in_b : '0;
    arr_init = {N{fire && first}};
  end

  always_comb begin
    cnt_d       = cnt_q;
    len_d       = len_q;
    cap_pend_d  = cap_pend_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (fire && first) begin
      len_d = cfg_len_eff;
    end
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (cap_pend_q) begin
      out_data_d  = arr_result;
      out_valid_d = 1'b1;
      cap_pend_d  = 1'b0;
    end
    if (fire) begin
      if (last) begin
        cnt_d      = '0;
        cap_pend_d = 1'b1;
      end else begin
        cnt_d = cnt_q + LEN_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      len_q       <= '0;
      cap_pend_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      cap_pend_q  <= cap_pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (cnt_q != '0) || cap_pend_q || out_valid_q;

`ifdef MAC_SCHED_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    if (in_valid && !in_ready && !rst && (perf_stall_q != '1)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_mac_array_sched.sv
// Scoreboard bench for mac_array_sched with a behavioural 3-lane signed MAC array attached.
module tb_mac_array_sched;
  localparam int N = 3;

  typedef logic [N-1:0][15:0] vec_t;

  logic               clk;
  logic               rst;
  logic [7:0]         cfg_len;
  logic               in_valid;
  logic               in_ready;
  logic [N-1:0][7:0]  in_a, in_b;
  logic [N-1:0]       arr_init;
  logic [N-1:0][7:0]  arr_a, arr_b;
  logic [N-1:0][15:0] arr_result;
  logic               out_valid;
  logic               out_ready;
  logic [N-1:0][15:0] out_data;
  logic               busy;
`ifdef MAC_SCHED_PERF_EN
  logic [31:0]        perf_stall;
`endif

  mac_array_sched dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_len    (cfg_len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .arr_init   (arr_init),
    .arr_a      (arr_a),
    .arr_b      (arr_b),
    .arr_result (arr_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
`ifdef MAC_SCHED_PERF_EN
    ,
    .perf_stall (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural MAC array: acc <= init ? a*b : acc + a*b, wrapping at 16 bits.
  logic signed [15:0] acc [N];
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) acc[i] <= '0;
      else if (arr_init[i]) acc[i] <= $signed(arr_a[i]) * $signed(arr_b[i]);
      else acc[i] <= acc[i] + $signed(arr_a[i]) * $signed(arr_b[i]);
    end
  end
  always_comb begin
    for (int i = 0; i < N; i++) arr_result[i] = acc[i];
  end

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_checks = 0;
  int   n_fail = 0;
  int   n_push = 0;
  int   n_pop = 0;
  vec_t exp_q[$];

  int   last_fcyc;
  int   last_waits;
  logic last_init;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_exp(input int e0, input int e1, input int e2);
    vec_t v;
    v[0] = 16'(e0);
    v[1] = 16'(e1);
    v[2] = 16'(e2);
    exp_q.push_back(v);
    n_push++;
  endtask

  // Monitor: compare every accepted result against the oldest expected vector.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL result_unexpected: got %h expected none", out_data);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        n_pop++;
        if (out_data !== e) begin
          n_fail++;
          $display("FAIL result_%0d: got %h expected %h", n_pop, out_data, e);
        end
      end
    end
  end

  task automatic set_vec(input int a0, input int b0, input int a1, input int b1,
                         input int a2, input int b2);
    in_valid = 1'b1;
    in_a[0] = 8'(a0); in_b[0] = 8'(b0);
    in_a[1] = 8'(a1); in_b[1] = 8'(b1);
    in_a[2] = 8'(a2); in_b[2] = 8'(b2);
  endtask

  // Called at posedge+1; returns at posedge+1 after the element has fired.
  task automatic send(input int a0, input int b0, input int a1, input int b1,
                      input int a2, input int b2);
    set_vec(a0, b0, a1, b1, a2, b2);
    last_waits = 0;
    @(negedge clk);
    while (!in_ready && last_waits < 50) begin
      last_waits++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    last_init = arr_init[0];
    @(posedge clk);
    #1;
    last_fcyc = cyc;
  endtask

  task automatic wait_out_valid(input string nm);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk(nm, out_valid, 1);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    in_valid = 1'b0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk(nm, busy, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int f1, f2, f3, sumw, bad, stall;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; cfg_len = 8'd3; out_ready = 1'b1;

    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_arr_init", arr_init, 0);
    chk("rst_arr_ab", {arr_a, arr_b}, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // len=3; cfg_len change after the first element must not shorten the product
    cfg_len = 8'd3;
    push_exp(32, -9, -45);
    send(1, 4, 2, -1, -3, 5);
    chk("t1_init_first", last_init, 1);
    cfg_len = 8'd1;
    send(2, 5, 3, -1, -3, 5);
    chk("t1_init_second", last_init, 0);
    send(3, 6, 4, -1, -3, 5);
    chk("t1_init_third", last_init, 0);
    in_valid = 1'b0;
    f1 = last_fcyc;
    wait_out_valid("t1_out_valid");
    chk("t1_latency", cyc - f1, 1);
    wait_idle("t1_idle");

    // back-to-back len=2 with no gap
    cfg_len = 8'd2;
    push_exp(26, 2, -16);
    push_exp(-13, 25, 0);
    send(2, 3, 1, 1, -4, 4);     f1 = last_fcyc; sumw = last_waits;
    send(4, 5, 1, 1, 0, 0);      sumw += last_waits;
    send(-1, 7, 0, 9, 10, 10);   sumw += last_waits;
    send(-2, 3, 5, 5, 10, -10);  sumw += last_waits;
    chk("t2_no_wait", sumw, 0);
    chk("t2_span", last_fcyc - f1, 3);
    wait_idle("t2_idle");

    // bubbles inside a len=3 product
    cfg_len = 8'd3;
    push_exp(300, -30, -300);
    send(10, 10, 10, -1, -10, 10);
    in_valid = 1'b0;
    bad = 0;
    repeat (2) begin
      @(negedge clk);
      if (arr_a != '0 || arr_b != '0 || arr_init != '0) bad++;
      @(posedge clk);
    end
    #1;
    chk("t3_bubble_zero", bad, 0);
    send(10, 10, 10, -1, -10, 10);
    send(10, 10, 10, -1, -10, 10);
    wait_idle("t3_idle");

    // backpressure: next product's last element held until the result is read
    out_ready = 1'b0;
    cfg_len = 8'd2;
    push_exp(5, 9, -24);
    push_exp(37, -49, 8);
    send(1, 1, 3, 3, -5, 5);
    send(2, 2, 0, 0, 1, 1);
    in_valid = 1'b0;
    wait_out_valid("t4_a_valid");
    @(posedge clk); #1;
    send(6, 6, -7, 7, 2, 2);
    chk("t4_nonlast_flows", last_waits, 0);
    set_vec(1, 1, 0, 1, 2, 2);
    stall = 0;
    repeat (3) begin
      @(negedge clk);
      if (in_ready) stall++;
    end
    chk("t4_last_held", stall, 0);
    chk("t4_busy", busy, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(1, 1, 0, 1, 2, 2);
    wait_idle("t4_idle");

    // len=0 and len=1: one product every two cycles
    cfg_len = 8'd0;
    push_exp(-16256, 16384, 0);
    push_exp(-16256, 16384, 0);
    push_exp(-16256, 16384, 0);
    send(127, -128, -128, -128, 0, 5); f1 = last_fcyc;
    send(127, -128, -128, -128, 0, 5); f2 = last_fcyc;
    cfg_len = 8'd1;
    send(127, -128, -128, -128, 0, 5); f3 = last_fcyc;
    chk("t5_len0_rate", f2 - f1, 2);
    chk("t5_len1_rate", f3 - f2, 2);
    wait_idle("t5_idle");

    // wraparound modulo 2^16
    cfg_len = 8'd2;
    push_exp(32258, -32768, 32513);
    send(127, 127, -128, -128, -128, -128);
    send(127, 127, -128, -128, 127, 127);
    wait_idle("t5_wrap_idle");

    // reset after 2 of 3 elements discards the partial product
    cfg_len = 8'd3;
    send(50, 50, 50, 50, 50, 50);
    send(50, 50, 50, 50, 50, 50);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    push_exp(3, 3, -18);
    send(1, 1, 1, 1, 2, -3);
    chk("t6_init_after_rst", last_init, 1);
    send(1, 1, 1, 1, 2, -3);
    send(1, 1, 1, 1, 2, -3);
    wait_idle("t6_idle");

    chk("all_results_popped", n_pop, n_push);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
